prng_scheduler: RTL and testbench
=================================

PRNG_SCHEDULER -- requirements
Module: prng_scheduler

Interface
REQ-001 Parameter RND, default 1: width in bits of one random word; SHALL match the attached PRNG's RND.
REQ-002 Parameter NREQ, default 2: number of consumers, legal range 2..16.
REQ-003 Parameter RESEED_PERIOD, default 1024: words delivered between automatic reseeds; 0 disables automatic reseeding.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 seed_valid  input  1  external seed source has a seed available.
REQ-007 seed_ready  output  1  scheduler accepts a seed this cycle.
REQ-008 seed_in  input  80  seed word from the external source.
REQ-009 force_reseed  input  1  pulse requesting an immediate reseed.
REQ-010 prng_start_reseed  output  1  start pulse to the PRNG.
REQ-011 prng_seed  output  80  registered seed presented to the PRNG.
REQ-012 prng_busy  input  1  PRNG reseed in progress.
REQ-013 prng_out_valid  input  1  PRNG SVRS valid.
REQ-014 prng_out_ready  output  1  PRNG SVRS ready.
REQ-015 prng_rnd  input  RND  PRNG random word.
REQ-016 cons_ready  input  NREQ  per-consumer ready (request).
REQ-017 cons_valid  output  NREQ  per-consumer valid; at most one bit set.
REQ-018 cons_rnd  output  RND  shared data bus; equals prng_rnd.
REQ-019 serving  output  1  high in state SERVE.

Function
REQ-020 FSM states: SEED_WAIT, RESEED_START, RESEED_BUSY, SERVE; state encodings are 2 bits.
REQ-021 SEED_WAIT: seed_ready=1. On seed_valid, capture seed_in into the seed register and move to RESEED_START.
REQ-022 RESEED_START: prng_start_reseed=1 for exactly one cycle, word counter cleared, then unconditional move to RESEED_BUSY.
REQ-023 RESEED_BUSY: stay until prng_busy=0 and prng_out_valid=1, then move to SERVE.
REQ-024 Outside SERVE: cons_valid=0 and prng_out_ready=0; no word is consumed.
REQ-025 SERVE grant: rotating priority. The grant is the first index i with cons_ready[i]=1, searching from ptr upward and wrapping modulo NREQ. The grant is one-hot or zero.
REQ-026 SERVE outputs: cons_valid = grant AND prng_out_valid; prng_out_ready = OR of grant.
REQ-027 Consumers SHALL NOT derive cons_ready from cons_valid, because valid depends combinationally on ready.
REQ-028 Transfer is prng_out_valid AND prng_out_ready. On a transfer, ptr becomes (granted index + 1) mod NREQ. Otherwise ptr holds.
REQ-029 The word counter has width clog2(RESEED_PERIOD+1). It increments on each transfer.
REQ-030 Automatic reseed: when RESEED_PERIOD is not 0, a transfer with counter = RESEED_PERIOD-1 delivers its word and moves the FSM to SEED_WAIT.
REQ-031 force_reseed in SERVE moves the FSM to SEED_WAIT. A transfer in the same cycle completes and is counted.
REQ-032 Simultaneous force_reseed and last-period transfer cause a single move to SEED_WAIT.
REQ-033 force_reseed outside SERVE is ignored.
REQ-034 prng_seed is driven only from the seed register and is stable from RESEED_START onward.
REQ-035 prng_busy rising while in SERVE moves the FSM to RESEED_BUSY (protocol recovery).

Reset
REQ-036 On rst: state=SEED_WAIT, ptr=0, counter=0, seed register=0, prng_start_reseed=0, cons_valid=0, prng_out_ready=0, serving=0.
REQ-037 rst mid-reseed or mid-serve aborts without a pulse. The PRNG SHALL be reset by the same rst at top level.

Structure
REQ-038 Shared package prng_sched_pkg holds the state encodings and the seed width constant (80).
REQ-039 Sub-module rr_arbiter (NREQ requests, ptr input, one-hot grant output) implements the rotating priority, combinationally.

Verification
(Parameters: NREQ=3, RND=8, RESEED_PERIOD=4.)
REQ-040 Reset, then seed_valid=1 with seed 0x1234... -> seed_ready for 1 cycle; prng_start_reseed exactly 1 cycle later; serving only after busy falls and valid rises.
REQ-041 cons_ready=3'b111 constant in SERVE -> grants 0,1,2,0 on consecutive transfers.
REQ-042 cons_ready=3'b101 constant -> grants 0,2,0,2; cons_valid[1] never set.
REQ-043 4 transfers -> 4th word delivered, then seed_ready=1 and serving=0; no 5th transfer before the new seed arrives.
REQ-044 force_reseed in the same cycle as the 2nd transfer -> word delivered, SEED_WAIT entered, counter restarts at 0 after the reseed.
REQ-045 rst asserted while in RESEED_BUSY -> next cycle seed_ready=1, all outputs at reset values, ptr=0.

Source files
------------

// File: rtl/prng_sched_pkg.sv
// rtl/prng_sched_pkg.sv - shared state encodings and seed width for prng_scheduler
package prng_sched_pkg;

    localparam int SEED_W = 80;

    typedef enum logic [1:0] {
        ST_SEED_WAIT    = 2'd0,
        ST_RESEED_START = 2'd1,
        ST_RESEED_BUSY  = 2'd2,
        ST_SERVE        = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority arbiter, search starts at ptr
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [PW:0]   idx_w;
    logic [PW-1:0] idx;
    logic          found;

    // One extra bit on the index so ptr+off can be wrapped for non power-of-two NREQ
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx_w = '0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx_w = {1'b0, ptr} + (PW+1)'(off);
            if (idx_w >= NREQ_W) begin
                idx_w = idx_w - NREQ_W;
            end
            idx = idx_w[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng_scheduler.sv
// rtl/prng_scheduler.sv - seeds a PRNG and shares its words among NREQ consumers
module prng_scheduler
    import prng_sched_pkg::*;
#(
    parameter int RND           = 1,
    parameter int NREQ          = 2,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              force_reseed,
    output logic              prng_start_reseed,
    output logic [SEED_W-1:0] prng_seed,
    input  logic              prng_busy,
    input  logic              prng_out_valid,
    output logic              prng_out_ready,
    input  logic [RND-1:0]    prng_rnd,
    input  logic [NREQ-1:0]   cons_ready,
    output logic [NREQ-1:0]   cons_valid,
    output logic [RND-1:0]    cons_rnd,
    output logic              serving
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (RESEED_PERIOD > 0) ? $clog2(RESEED_PERIOD + 1) : 1;
    localparam bit AUTO_EN = (RESEED_PERIOD != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((RESEED_PERIOD > 0) ? RESEED_PERIOD - 1 : 0);
    localparam logic [PW-1:0] PTR_MAX  = PW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     grant_idx;
    logic              in_serve;
    logic              xfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (cons_ready),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end
        end
    end

    assign in_serve = (state_q == ST_SERVE);
    assign xfer     = in_serve && prng_out_valid && (|grant);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        busy_d  = prng_busy;
        case (state_q)
            ST_SEED_WAIT: begin
                if (seed_valid) begin
                    seed_d  = seed_in;
                    state_d = ST_RESEED_START;
                end
            end
            ST_RESEED_START: begin
                cnt_d   = '0;
                state_d = ST_RESEED_BUSY;
            end
            ST_RESEED_BUSY: begin
                if (!prng_busy && prng_out_valid) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (xfer) begin
                    ptr_d = (grant_idx == PTR_MAX) ? '0 : grant_idx + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
                // A pending reseed wins over busy recovery: a new seed is needed anyway
                if (force_reseed || (AUTO_EN && xfer && (cnt_q == CNT_LAST))) begin
                    state_d = ST_SEED_WAIT;
                end else if (prng_busy && !busy_q) begin
                    state_d = ST_RESEED_BUSY;
                end
            end
            default: state_d = ST_SEED_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SEED_WAIT;
            ptr_q   <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            busy_q  <= busy_d;
        end
    end

    assign seed_ready        = (state_q == ST_SEED_WAIT);
    assign prng_start_reseed = (state_q == ST_RESEED_START);
    assign serving           = in_serve;
    assign prng_seed         = seed_q;
    assign prng_out_ready    = in_serve && (|grant);
    assign cons_valid        = (in_serve && prng_out_valid) ? grant : '0;
    assign cons_rnd          = prng_rnd;

endmodule

// File: tb/tb_prng_scheduler.sv
// tb/tb_prng_scheduler.sv - scoreboard bench for prng_scheduler with directed vectors
module tb_prng_scheduler;

    localparam int NREQ = 3;
    localparam int RND  = 8;
    localparam int RP   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            seed_valid = 1'b0;
    logic            seed_ready;
    logic [79:0]     seed_in = '0;
    logic            force_reseed = 1'b0;
    logic            prng_start_reseed;
    logic [79:0]     prng_seed;
    logic            prng_busy = 1'b0;
    logic            prng_out_valid = 1'b0;
    logic            prng_out_ready;
    logic [RND-1:0]  prng_rnd = '0;
    logic [NREQ-1:0] cons_ready = '0;
    logic [NREQ-1:0] cons_valid;
    logic [RND-1:0]  cons_rnd;
    logic            serving;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int             idx;
        logic [RND-1:0] word;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [NREQ-1:0] mon_oh;

    prng_scheduler #(
        .RND           (RND),
        .NREQ          (NREQ),
        .RESEED_PERIOD (RP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .seed_valid        (seed_valid),
        .seed_ready        (seed_ready),
        .seed_in           (seed_in),
        .force_reseed      (force_reseed),
        .prng_start_reseed (prng_start_reseed),
        .prng_seed         (prng_seed),
        .prng_busy         (prng_busy),
        .prng_out_valid    (prng_out_valid),
        .prng_out_ready    (prng_out_ready),
        .prng_rnd          (prng_rnd),
        .cons_ready        (cons_ready),
        .cons_valid        (cons_valid),
        .cons_rnd          (cons_rnd),
        .serving           (serving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_seed_ready"}, 80'(seed_ready), 80'd1);
        chk({tag, "_serving"}, 80'(serving), 80'd0);
        chk({tag, "_start"}, 80'(prng_start_reseed), 80'd0);
        chk({tag, "_cons_valid"}, 80'(cons_valid), 80'd0);
        chk({tag, "_out_ready"}, 80'(prng_out_ready), 80'd0);
    endtask

    // Ends at posedge+1 of the first SERVE cycle
    task automatic do_seed(input logic [79:0] s, input logic frc);
        seed_valid = 1'b1; seed_in = s; cons_ready = '0;
        prng_out_valid = 1'b0; prng_busy = 1'b0; force_reseed = 1'b0;
        mid();
        chk("seed_offer_ready", 80'(seed_ready), 80'd1);
        chk("seed_offer_no_start", 80'(prng_start_reseed), 80'd0);
        tick();
        seed_valid = 1'b0; seed_in = ~s;
        mid();
        chk("start_pulse", 80'(prng_start_reseed), 80'd1);
        chk("seed_ready_one_cycle", 80'(seed_ready), 80'd0);
        chk("prng_seed_captured", prng_seed, s);
        tick();
        prng_busy = 1'b1; force_reseed = frc;
        mid();
        chk("start_one_cycle", 80'(prng_start_reseed), 80'd0);
        chk("busy_not_serving", 80'(serving), 80'd0);
        tick();
        force_reseed = 1'b0;
        mid();
        chk("prng_seed_stable", prng_seed, s);
        tick();
        prng_busy = 1'b0;
        mid();
        chk("no_serve_without_valid", 80'(serving), 80'd0);
        tick();
        prng_out_valid = 1'b1;
        mid();
        chk("serve_next_edge", 80'(serving), 80'd0);
        tick();
    endtask

    task automatic serve_cycle(input logic [NREQ-1:0] rdy, input logic [RND-1:0] w,
                               input int gi, input logic frc);
        cons_ready = rdy; prng_rnd = w; prng_out_valid = 1'b1; force_reseed = frc;
        exp_q.push_back('{idx: gi, word: w});
        mid();
        chk("serving", 80'(serving), 80'd1);
        tick();
        force_reseed = 1'b0;
    endtask

    task automatic idle_after(input string tag);
        mid();
        chk_idle(tag);
        tick();
        mid();
        chk_idle({tag, "_hold"});
        chk({tag, "_queue_drained"}, 80'(exp_q.size()), 80'd0);
        tick();
    endtask

    // Monitor: every transfer must match the head of the expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            if ((cons_valid != '0) && !prng_out_ready) begin
                checks++;
                fails++;
                $display("FAIL valid_without_ready: cons_valid=%b prng_out_ready=0", cons_valid);
            end
            if (prng_out_valid && prng_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_xfer: cons_valid=%b expected no transfer", cons_valid);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_oh = NREQ'(1) << mon_e.idx;
                    chk("grant", 80'(cons_valid), 80'(mon_oh));
                    chk("word", 80'(cons_rnd), 80'(mon_e.word));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mid();
        chk_idle("reset");
        chk("reset_seed", prng_seed, 80'd0);
        tick();

        do_seed(80'h1234_5678_9ABC_DEF0_1122, 1'b0);
        serve_cycle(3'b111, 8'hA0, 0, 1'b0);
        serve_cycle(3'b111, 8'hA1, 1, 1'b0);
        serve_cycle(3'b111, 8'hA2, 2, 1'b0);
        serve_cycle(3'b111, 8'hA3, 0, 1'b0);
        idle_after("auto_reseed");

        cons_ready = '0; prng_out_valid = 1'b0;
        seed_valid = 1'b1; seed_in = 80'hCAFE;
        tick();
        seed_valid = 1'b0;
        tick();
        prng_busy = 1'b1;
        mid();
        chk("pre_abort_busy", 80'(serving), 80'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; prng_busy = 1'b0;
        mid();
        chk_idle("rst_abort");
        chk("rst_abort_seed", prng_seed, 80'd0);
        tick();

        do_seed(80'h0F0F_0000_0000_0000_ABCD, 1'b1);
        serve_cycle(3'b101, 8'hB0, 0, 1'b0);
        serve_cycle(3'b101, 8'hB1, 2, 1'b0);
        serve_cycle(3'b101, 8'hB2, 0, 1'b0);
        serve_cycle(3'b101, 8'hB3, 2, 1'b0);
        idle_after("auto_reseed2");

        do_seed(80'h5555, 1'b0);
        cons_ready = 3'b111; prng_out_valid = 1'b0;
        mid();
        chk("novalid_out_ready", 80'(prng_out_ready), 80'd1);
        chk("novalid_cons_valid", 80'(cons_valid), 80'd0);
        tick();
        serve_cycle(3'b111, 8'hC0, 0, 1'b0);
        serve_cycle(3'b111, 8'hC1, 1, 1'b1);
        mid();
        chk_idle("force");
        tick();

        do_seed(80'h9999, 1'b0);
        serve_cycle(3'b111, 8'hD0, 2, 1'b0);
        serve_cycle(3'b111, 8'hD1, 0, 1'b0);
        serve_cycle(3'b111, 8'hD2, 1, 1'b0);
        serve_cycle(3'b111, 8'hD3, 2, 1'b0);
        idle_after("after_force");

        chk("final_queue_empty", 80'(exp_q.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
